// File: rtl/ysyx_22050019_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_pipe_ctrl
//   Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
//   Decides, each cycle, which pipeline registers hold, which load a bubble,
//   and whether the PC is redirected. Owns the multi-cycle MDU wait and the
//   deferral of an EX redirect that lands while a fetch is outstanding.
//
//   Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush
//   performance counters. Without it, both counter ports read 0 and no
//   counter flops exist.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   id_rs1_*/id_rs2_*     ID source registers and their read enables
//   ex_rd_addr_i, ex_wen_i, ex_is_load_i   EX destination / load info
//   ex_redirect_i, ex_redirect_pc_i        EX taken-mispredict and target
//   mdu_start_i, mdu_done_i                multi-cycle mul/div handshake
//   if_busy_i, mem_busy_i                  fetch / LSU access outstanding
//   pc_stall_o, *_stall_o                  hold PC / pipeline register
//   *_flush_o                              load a bubble into register
//   pc_redirect_o, pc_redirect_addr_o      PC redirect and its target
//   perf_stall_cnt_o, perf_flush_cnt_o     performance counters
// ---------------------------------------------------------------------------
module ysyx_22050019_pipe_ctrl #(
  parameter int XLEN   = 64,
  parameter int RAW    = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAW-1:0]    id_rs1_addr_i,
  input  logic              id_rs1_ren_i,
  input  logic [RAW-1:0]    id_rs2_addr_i,
  input  logic              id_rs2_ren_i,
  input  logic [RAW-1:0]    ex_rd_addr_i,
  input  logic              ex_wen_i,
  input  logic              ex_is_load_i,
  input  logic              ex_redirect_i,
  input  logic [XLEN-1:0]   ex_redirect_pc_i,
  input  logic              mdu_start_i,
  input  logic              mdu_done_i,
  input  logic              if_busy_i,
  input  logic              mem_busy_i,
  output logic              pc_stall_o,
  output logic              if_id_stall_o,
  output logic              id_ex_stall_o,
  output logic              ex_mem_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_flush_o,
  output logic              mem_wb_flush_o,
  output logic              pc_redirect_o,
  output logic [XLEN-1:0]   pc_redirect_addr_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o,
  output logic [PERF_W-1:0] perf_flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MDU_WAIT   = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  // An mdu_done pulse can arrive while mem_busy freezes the pipe; remember it
  // so the MDU wait still ends once the LSU releases.
  logic              done_seen_q, done_seen_d;
  logic              load_use;

  // x0 never carries a dependency, so rd==0 suppresses the hazard.
  assign load_use = ex_is_load_i && ex_wen_i && (ex_rd_addr_i != '0) &&
                    ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d            = state_q;
    pend_pc_d          = pend_pc_q;
    done_seen_d        = done_seen_q;
    pc_stall_o         = 1'b0;
    if_id_stall_o      = 1'b0;
    id_ex_stall_o      = 1'b0;
    ex_mem_stall_o     = 1'b0;
    if_id_flush_o      = 1'b0;
    id_ex_flush_o      = 1'b0;
    ex_mem_flush_o     = 1'b0;
    mem_wb_flush_o     = 1'b0;
    pc_redirect_o      = 1'b0;
    pc_redirect_addr_o = '0;

    // Controls are forced quiet while reset is held.
    if (rst_n) begin
      if (mem_busy_i) begin
        // LSU stall freezes everything up to MEM; state is untouched.
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_flush_o = 1'b1;
        if (state_q == REDIR_PEND) if_id_flush_o = 1'b1;
        if (state_q == MDU_WAIT && mdu_done_i) done_seen_d = 1'b1;
      end else if (state_q == MDU_WAIT) begin
        if (mdu_done_i || done_seen_q) begin
          state_d     = RUN;
          done_seen_d = 1'b0;
        end else begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_stall_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
        end
      end else if (state_q == RUN && mdu_start_i && !mdu_done_i) begin
        // start together with done is a single-cycle op and needs no wait.
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
        state_d        = MDU_WAIT;
      end else if (state_q == RUN && ex_redirect_i) begin
        // The ID instruction is wrong-path, so a load-use on it is moot.
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        if (if_busy_i) begin
          pend_pc_d = ex_redirect_pc_i;
          state_d   = REDIR_PEND;
        end else begin
          pc_redirect_o      = 1'b1;
          pc_redirect_addr_o = ex_redirect_pc_i;
        end
      end else if (state_q == REDIR_PEND) begin
        // Whatever the outstanding fetch returns is wrong-path.
        if_id_flush_o = 1'b1;
        if (!if_busy_i) begin
          pc_redirect_o      = 1'b1;
          pc_redirect_addr_o = pend_pc_q;
          state_d            = RUN;
        end
      end else if (load_use) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (if_busy_i) begin
        pc_stall_o    = 1'b1;
        if_id_flush_o = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_pc_q   <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      done_seen_q <= done_seen_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Free-running counters; they wrap naturally at 2^PERF_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall_o)    stall_cnt_q <= stall_cnt_q + 1'b1;
      if (id_ex_flush_o) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050019_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050019_pipe_ctrl
//   Directed bench for the pipeline stall/flush sequencer. Inputs change on
//   the falling edge; outputs are sampled 1ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22050019_pipe_ctrl;

  localparam int XLEN   = 64;
  localparam int RAW    = 5;
  localparam int PERF_W = 32;

  // Control vector order:
  // [8]pc_stall [7]if_id_stall [6]id_ex_stall [5]ex_mem_stall
  // [4]if_id_flush [3]id_ex_flush [2]ex_mem_flush [1]mem_wb_flush [0]pc_redirect
  localparam logic [8:0] C_NONE      = 9'b000000000;
  localparam logic [8:0] C_LU        = 9'b110001000;
  localparam logic [8:0] C_MDU       = 9'b111000100;
  localparam logic [8:0] C_REDIR     = 9'b000011001;
  localparam logic [8:0] C_REDIR_BSY = 9'b000011000;
  localparam logic [8:0] C_PEND      = 9'b000010000;
  localparam logic [8:0] C_PEND_GO   = 9'b000010001;
  localparam logic [8:0] C_MEMB      = 9'b111100010;
  localparam logic [8:0] C_MEMB_PEND = 9'b111110010;
  localparam logic [8:0] C_FETCH     = 9'b100010000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RAW-1:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic              id_rs1_ren, id_rs2_ren, ex_wen, ex_is_load;
  logic              ex_redirect;
  logic [XLEN-1:0]   ex_redirect_pc;
  logic              mdu_start, mdu_done, if_busy, mem_busy;
  logic              pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic              pc_redirect;
  logic [XLEN-1:0]   pc_redirect_addr;
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22050019_pipe_ctrl #(.XLEN(XLEN), .RAW(RAW), .PERF_W(PERF_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_rs1_addr_i      (id_rs1_addr),
    .id_rs1_ren_i       (id_rs1_ren),
    .id_rs2_addr_i      (id_rs2_addr),
    .id_rs2_ren_i       (id_rs2_ren),
    .ex_rd_addr_i       (ex_rd_addr),
    .ex_wen_i           (ex_wen),
    .ex_is_load_i       (ex_is_load),
    .ex_redirect_i      (ex_redirect),
    .ex_redirect_pc_i   (ex_redirect_pc),
    .mdu_start_i        (mdu_start),
    .mdu_done_i         (mdu_done),
    .if_busy_i          (if_busy),
    .mem_busy_i         (mem_busy),
    .pc_stall_o         (pc_stall),
    .if_id_stall_o      (if_id_stall),
    .id_ex_stall_o      (id_ex_stall),
    .ex_mem_stall_o     (ex_mem_stall),
    .if_id_flush_o      (if_id_flush),
    .id_ex_flush_o      (id_ex_flush),
    .ex_mem_flush_o     (ex_mem_flush),
    .mem_wb_flush_o     (mem_wb_flush),
    .pc_redirect_o      (pc_redirect),
    .pc_redirect_addr_o (pc_redirect_addr),
    .perf_stall_cnt_o   (perf_stall_cnt),
    .perf_flush_cnt_o   (perf_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect};
  endfunction

  task automatic idle_inputs();
    id_rs1_addr = '0; id_rs1_ren = 1'b0;
    id_rs2_addr = '0; id_rs2_ren = 1'b0;
    ex_rd_addr  = '0; ex_wen = 1'b0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; ex_redirect_pc = '0;
    mdu_start = 1'b0; mdu_done = 1'b0;
    if_busy = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_load(input logic [RAW-1:0] rd);
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd_addr = rd;
  endtask

  // Sample settled outputs, then move to the next falling edge.
  task automatic check_cycle(input string tag, input logic [8:0] exp_ctl,
                             input logic [XLEN-1:0] exp_addr);
    #1;
    check({tag, ".ctl"}, 64'(ctl()), 64'(exp_ctl));
    check({tag, ".addr"}, 64'(pc_redirect_addr), 64'(exp_addr));
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    // Reset with hazards present: controls stay quiet.
    mem_busy = 1'b1; if_busy = 1'b1;
    check_cycle("reset", C_NONE, '0);
    idle_inputs();
    check_cycle("reset2", C_NONE, '0);
    check("reset.perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("reset.perf_flush", 64'(perf_flush_cnt), 64'd0);
    rst_n = 1'b1;
    check_cycle("run_idle", C_NONE, '0);

    // Load-use via rs1, then the load has advanced.
    set_load(5'd5); id_rs1_addr = 5'd5; id_rs1_ren = 1'b1;
    check_cycle("lu_rs1", C_LU, '0);
    idle_inputs();
    check_cycle("lu_after", C_NONE, '0);
    // rd=x0 never hazards.
    set_load(5'd0); id_rs1_addr = 5'd0; id_rs1_ren = 1'b1;
    check_cycle("lu_x0", C_NONE, '0);
    // Matching address but read enable low.
    set_load(5'd9); id_rs1_addr = 5'd9; id_rs1_ren = 1'b0;
    check_cycle("lu_noren", C_NONE, '0);
    // Not a load.
    idle_inputs(); ex_wen = 1'b1; ex_rd_addr = 5'd9; id_rs1_addr = 5'd9; id_rs1_ren = 1'b1;
    check_cycle("lu_notload", C_NONE, '0);
    // Load-use via rs2.
    idle_inputs(); set_load(5'd7); id_rs2_addr = 5'd7; id_rs2_ren = 1'b1; id_rs1_addr = 5'd3;
    id_rs1_ren = 1'b1;
    check_cycle("lu_rs2", C_LU, '0);
    idle_inputs(); set_load(5'd31); id_rs1_addr = 5'd31; id_rs1_ren = 1'b1;
    check_cycle("lu_rs1_b", C_LU, '0);

    // Redirect with fetch idle; load-use inputs present but masked.
    ex_redirect = 1'b1; ex_redirect_pc = 64'h8000_0100;
    check_cycle("redir_idle", C_REDIR, 64'h8000_0100);
    idle_inputs();
    check_cycle("redir_after", C_NONE, '0);

`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", 64'(perf_stall_cnt), 64'd3);
    check("perf_flush", 64'(perf_flush_cnt), 64'd4);
`endif

    // Redirect with fetch busy: deferred until fetch goes idle.
    ex_redirect = 1'b1; ex_redirect_pc = 64'h8000_0200; if_busy = 1'b1;
    check_cycle("redir_busy0", C_REDIR_BSY, '0);
    ex_redirect = 1'b0; ex_redirect_pc = 64'hDEAD_BEEF;
    check_cycle("redir_busy1", C_PEND, '0);
    check_cycle("redir_busy2", C_PEND, '0);
    if_busy = 1'b0;
    check_cycle("redir_go", C_PEND_GO, 64'h8000_0200);
    idle_inputs();
    check_cycle("redir_done", C_NONE, '0);

    // MDU: start, 7 wait cycles, done in the 9th cycle.
    mdu_start = 1'b1;
    check_cycle("mdu_start", C_MDU, '0);
    mdu_start = 1'b0;
    for (int i = 1; i < 8; i++) check_cycle($sformatf("mdu_wait%0d", i), C_MDU, '0);
    mdu_done = 1'b1;
    check_cycle("mdu_done", C_NONE, '0);
    mdu_done = 1'b0; if_busy = 1'b1;
    check_cycle("mdu_back_run", C_FETCH, '0);
    idle_inputs();

    // Single-cycle MDU op.
    mdu_start = 1'b1; mdu_done = 1'b1;
    check_cycle("mdu_1cyc", C_NONE, '0);
    idle_inputs();
    check_cycle("mdu_1cyc_after", C_NONE, '0);

    // mem_busy over MDU_WAIT, done arriving in the 2nd busy cycle.
    mdu_start = 1'b1;
    check_cycle("mb_start", C_MDU, '0);
    mdu_start = 1'b0;
    check_cycle("mb_wait", C_MDU, '0);
    mem_busy = 1'b1;
    check_cycle("mb_busy1", C_MEMB, '0);
    mdu_done = 1'b1;
    check_cycle("mb_busy2", C_MEMB, '0);
    mdu_done = 1'b0;
    check_cycle("mb_busy3", C_MEMB, '0);
    check_cycle("mb_busy4", C_MEMB, '0);
    mem_busy = 1'b0;
    check_cycle("mb_release", C_NONE, '0);
    if_busy = 1'b1;
    check_cycle("mb_run", C_FETCH, '0);
    idle_inputs();

    // Reset while a redirect is pending.
    ex_redirect = 1'b1; ex_redirect_pc = 64'h8000_0300; if_busy = 1'b1;
    check_cycle("rp_capture", C_REDIR_BSY, '0);
    ex_redirect = 1'b0; mem_busy = 1'b1;
    check_cycle("rp_membusy", C_MEMB_PEND, '0);
    mem_busy = 1'b0;
    check_cycle("rp_pend", C_PEND, '0);
    rst_n = 1'b0; if_busy = 1'b0;
    check_cycle("rp_reset", C_NONE, '0);
    rst_n = 1'b1;
    check_cycle("rp_after_reset", C_NONE, '0);
    if_busy = 1'b1;
    check_cycle("rp_run", C_FETCH, '0);
    idle_inputs();
    check_cycle("final_idle", C_NONE, '0);

`ifndef PIPE_CTRL_PERF_EN
    check("perf_off_stall", 64'(perf_stall_cnt), 64'd0);
    check("perf_off_flush", 64'(perf_flush_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_pipe_ctrl.md
Name: ysyx_22050019_pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Inputs: hazard and busy indications from fetch, decode, EX, the MDU and the LSU.
- Outputs: per-pipeline-register hold (stall) and bubble (flush) controls, plus the PC redirect.
- Owns the multi-cycle MDU wait and the deferral of a branch redirect that arrives while an instruction fetch is outstanding.

Parameters:
- XLEN, 64, PC/redirect address width.
- RAW, 5, register address width.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_rs1_addr_i  in  RAW  ID source register 1
- id_rs1_ren_i  in  1  ID reads rs1
- id_rs2_addr_i  in  RAW  ID source register 2
- id_rs2_ren_i  in  1  ID reads rs2
- ex_rd_addr_i  in  RAW  EX destination register
- ex_wen_i  in  1  EX writes rd
- ex_is_load_i  in  1  EX instruction is a load
- ex_redirect_i  in  1  branch/jump resolved taken-mispredict in EX
- ex_redirect_pc_i  in  XLEN  redirect target
- mdu_start_i  in  1  EX issues a multi-cycle mul/div
- mdu_done_i  in  1  MDU result valid (single-cycle pulse)
- if_busy_i  in  1  instruction fetch outstanding
- mem_busy_i  in  1  LSU access outstanding
- pc_stall_o  out  1  hold PC
- if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out  1 each  hold that pipeline register
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  load a bubble (commit=0) into that register
- pc_redirect_o  out  1  PC takes pc_redirect_addr_o next edge
- pc_redirect_addr_o  out  XLEN  redirect target
- perf_stall_cnt_o, perf_flush_cnt_o  out  PERF_W each  counters (see Optional Feature)

Behaviour:
- Reset is synchronous, active-low. While rst_n=0 at the edge: state=RUN, pending redirect cleared, pend_pc=0.
- All stall, flush and redirect outputs are 0 while in reset and in RUN with no hazard.
- States:
  - RUN: normal operation.
  - MDU_WAIT: a multi-cycle MDU operation is in progress.
  - REDIR_PEND: a redirect has been captured and is waiting for fetch to go idle.
- Outputs are combinational from state + inputs, zero-latency. Stall overrides flush on the same register; stall=1 means the register holds.
- Priority, highest first:
  1. mem_busy_i: stall PC, IF/ID, ID/EX, EX/MEM; mem_wb_flush_o=1. State is unchanged. In REDIR_PEND, if_id_flush_o stays 1. Every lower rule is masked.
  2. MDU_WAIT, or RUN with mdu_start_i: stall PC, IF/ID, ID/EX; ex_mem_flush_o=1. From RUN, go to MDU_WAIT. In the cycle where mdu_done_i=1, drop the stalls and ex_mem_flush_o, and return to RUN at the next edge. mdu_start_i and mdu_done_i in the same cycle means a 1-cycle op: no stall, stay in RUN.
  3. ex_redirect_i (RUN only): if_id_flush_o=1, id_ex_flush_o=1. This masks load-use (that ID instruction is wrong-path).
     - if_busy_i=0: pc_redirect_o=1, pc_redirect_addr_o=ex_redirect_pc_i.
     - if_busy_i=1: capture pend_pc<=ex_redirect_pc_i, go to REDIR_PEND, pc_redirect_o=0.
  4. REDIR_PEND: if_id_flush_o=1 every cycle, which discards the wrong-path fetch. When if_busy_i=0: pc_redirect_o=1, pc_redirect_addr_o=pend_pc, return to RUN. A new ex_redirect_i cannot occur here, because ID/EX is bubbled.
  5. Load-use: ex_is_load_i & ex_wen_i & ex_rd_addr_i!=0 & ((id_rs1_ren_i & rs1==rd) | (id_rs2_ren_i & rs2==rd)). Stall PC and IF/ID; id_ex_flush_o=1. Lasts exactly one cycle because the load advances.
  6. if_busy_i alone: pc_stall_o=1, if_id_flush_o=1. Downstream stages keep flowing.
- pc_redirect_addr_o=0 whenever pc_redirect_o=0.
- x0 never creates a hazard.
- Reset asserted mid-MDU_WAIT or mid-REDIR_PEND: the pending state is dropped; the core restarts from the reset PC.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt_o increments each cycle pc_stall_o=1.
  - perf_flush_cnt_o increments each cycle id_ex_flush_o=1.
  - Both reset to 0 and wrap modulo 2^PERF_W.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Load-use: EX ld rd=5 (ex_wen=1, is_load=1), ID add rs1=5 ren=1 -> exactly 1 cycle of pc_stall=if_id_stall=id_ex_flush=1. With rd=0 -> no stall.
- MDU: mdu_start pulse, mdu_done 8 cycles later -> PC/IF_ID/ID_EX stall and ex_mem_flush for 8 cycles, all 0 in the done cycle. start+done in the same cycle -> no stall.
- Redirect, fetch idle: ex_redirect=1, pc=0x8000_0100, if_busy=0 -> same cycle pc_redirect=1, addr=0x8000_0100, if_id_flush=id_ex_flush=1.
- Redirect, fetch busy: ex_redirect with if_busy=1 held 3 cycles -> pc_redirect=0 for 3 cycles with if_id_flush=1, then 1 cycle pc_redirect=1 with the captured addr.
- mem_busy for 4 cycles during MDU_WAIT with mdu_done arriving in the 2nd of those cycles -> stall all + mem_wb_flush; MDU exit and release only after mem_busy drops. Also: reset mid-REDIR_PEND -> all outputs 0, state RUN.
- PERF (macro on): 3 load-use stalls + 1 redirect -> perf_stall_cnt=3, perf_flush_cnt=4. Macro off -> both read 0.
